// File: rtl/adc_averager_if.sv
// Sample-in / average-out bus for adc_averager.
// Signal names follow the upstream ADC stage naming.
interface adc_averager_if;
    logic        response_valid_out;
    logic [11:0] ADC_out;
    logic        clear;
    logic [11:0] avg_out;
    logic [15:0] voltage_mV;
    logic        avg_valid;
    logic        filled;

    // Upstream stage: drives samples and flushes, observes the averaged result
    modport master (
        output response_valid_out,
        output ADC_out,
        output clear,
        input  avg_out,
        input  voltage_mV,
        input  avg_valid,
        input  filled
    );

    // Averager side
    modport slave (
        input  response_valid_out,
        input  ADC_out,
        input  clear,
        output avg_out,
        output voltage_mV,
        output avg_valid,
        output filled
    );
endinterface

// File: rtl/adc_averager.sv
// Moving-window averager for a 12-bit ADC stream.
// Keeps the last 2^LOG2_DEPTH samples in a circular buffer with a running sum;
// publishes the average and its millivolt equivalent one cycle after each
// sample once the window is full.
module adc_averager #(
    parameter int unsigned LOG2_DEPTH = 4,
    parameter int unsigned VREF_MV    = 5000
) (
    input  logic          MAX10_CLK1_50,
    input  logic          reset,
    adc_averager_if.slave bus_io
);

    localparam int unsigned Depth = 1 << LOG2_DEPTH;
    localparam int unsigned PtrW  = LOG2_DEPTH;
    localparam int unsigned CntW  = LOG2_DEPTH + 1;
    localparam int unsigned SumW  = 12 + LOG2_DEPTH;

    typedef enum logic {StFilling, StRunning} state_e;

    state_e            state_q, state_d;
    logic [11:0]       buf_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic              filled_q, filled_d;
    logic              pend_q, pend_d;
    logic [11:0]       avg_q, avg_d;
    logic [15:0]       volt_q, volt_d;
    logic              avg_valid_q, avg_valid_d;

    logic              accept;
    logic              fill_done;
    logic              upd_en;
    logic [11:0]       old_sample;
    logic [11:0]       avg_next;

    // FSM state register
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_q <= StFilling;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear always returns to filling
    always_comb begin
        state_d = state_q;
        if (bus_io.clear) begin
            state_d = StFilling;
        end else if (fill_done) begin
            state_d = StRunning;
        end
    end

    // FSM outputs: sample acceptance and averaged-result request
    always_comb begin
        // clear wins over a coincident strobe; the sample is dropped
        accept    = bus_io.response_valid_out && !bus_io.clear;
        fill_done = (state_q == StFilling) && accept && (count_q == CntW'(Depth - 1));
        upd_en    = accept && ((state_q == StRunning) || fill_done);
    end

    // Window bookkeeping: pointer, fill count, running sum
    always_comb begin
        old_sample = buf_q[wr_ptr_q];
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        sum_d      = sum_q;
        filled_d   = filled_q;
        pend_d     = upd_en;
        if (bus_io.clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            sum_d    = '0;
            filled_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (state_q == StFilling) begin
                // Buffer slots are untouched until written, so stale data never enters the sum
                count_d = count_q + CntW'(1);
                sum_d   = sum_q + SumW'(bus_io.ADC_out);
                if (fill_done) begin
                    filled_d = 1'b1;
                end
            end else begin
                sum_d = sum_q + SumW'(bus_io.ADC_out) - SumW'(old_sample);
            end
        end
    end

    // Window state registers
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            filled_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            filled_q <= filled_d;
            pend_q   <= pend_d;
        end
    end

    // Sample buffer; contents are never reset
    always_ff @(posedge MAX10_CLK1_50) begin
        if (accept) begin
            buf_q[wr_ptr_q] <= bus_io.ADC_out;
        end
    end

    // Result computation from the sum registered on the previous edge
    always_comb begin
        avg_next    = sum_q[LOG2_DEPTH +: 12];
        avg_d       = avg_q;
        volt_d      = volt_q;
        avg_valid_d = pend_q;
        if (pend_q) begin
            avg_d  = avg_next;
            volt_d = 16'((44'(avg_next) * 44'(VREF_MV)) >> 12);
        end
    end

    // Result registers; hold between updates
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            avg_q       <= '0;
            volt_q      <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_q       <= avg_d;
            volt_q      <= volt_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    // Drive bus outputs
    always_comb begin
        bus_io.avg_out    = avg_q;
        bus_io.voltage_mV = volt_q;
        bus_io.avg_valid  = avg_valid_q;
        bus_io.filled     = filled_q;
    end

endmodule

// File: tb/tb_adc_averager.sv
// Randomized and directed checks of adc_averager against a queue-based window model.
module tb_adc_averager;

    localparam int unsigned LOG2_DEPTH = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned VREF_MV    = 5000;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    adc_averager_if bus ();

    adc_averager #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .VREF_MV    (VREF_MV)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst),
        .bus_io        (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_valid  = 0;

    // Model: the window is simply the list of the most recent accepted samples
    int unsigned win[$];
    bit          pend;
    int unsigned pend_avg, pend_volt;
    int unsigned exp_avg, exp_volt;
    bit          exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        win.delete();
        pend      = 1'b0;
        exp_avg   = 0;
        exp_volt  = 0;
        exp_valid = 1'b0;
    endfunction

    function automatic void model_accept(input int unsigned s);
        int unsigned total;
        win.push_back(s);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
            total = 0;
            foreach (win[i]) total += win[i];
            pend      = 1'b1;
            pend_avg  = total / DEPTH;
            pend_volt = (pend_avg * VREF_MV) / 4096;
        end
    endfunction

    task automatic check_outputs();
        check_eq("avg_valid", bus.avg_valid, exp_valid);
        check_eq("filled", bus.filled, (win.size() == DEPTH));
        check_eq("avg_out", bus.avg_out, exp_avg);
        check_eq("voltage_mV", bus.voltage_mV, exp_volt);
    endtask

    // Apply one cycle of inputs, clock it, then compare against the model
    task automatic cycle(input bit strb, input logic [11:0] code, input bit clr);
        bus.response_valid_out = strb;
        bus.ADC_out            = code;
        bus.clear              = clr;
        @(posedge clk);
        #1;
        exp_valid = pend;
        if (pend) begin
            exp_avg  = pend_avg;
            exp_volt = pend_volt;
        end
        pend = 1'b0;
        if (clr) win.delete();
        else if (strb) model_accept(code);
        if (bus.avg_valid === 1'b1) n_valid++;
        check_outputs();
        bus.response_valid_out = 1'b0;
        bus.clear              = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit prev_strb;
        bit strb;
        bit clr;
        rst                    = 1'b1;
        bus.response_valid_out = 1'b0;
        bus.ADC_out            = '0;
        bus.clear              = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Fill with mid-scale: no result until the 16th sample
        n_valid = 0;
        for (int i = 0; i < 15; i++) cycle(1'b1, 12'h800, 1'b0);
        check_eq("fill15_no_valid", n_valid, 0);
        check_eq("fill15_filled", bus.filled, 1'b0);
        cycle(1'b1, 12'h800, 1'b0);
        check_eq("fill16_filled", bus.filled, 1'b1);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("mid_avg", bus.avg_out, 12'h800);
        check_eq("mid_volt", bus.voltage_mV, 16'd2500);
        check_eq("mid_valid", bus.avg_valid, 1'b1);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("mid_valid_pulse", bus.avg_valid, 1'b0);

        // One full-scale sample into the mid-scale window
        cycle(1'b1, 12'hFFF, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("step_avg", bus.avg_out, 12'h87F);
        check_eq("step_volt", bus.voltage_mV, 16'd2655);

        // Full-scale window: largest possible sum
        pulse_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'hFFF, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("full_avg", bus.avg_out, 12'd4095);
        check_eq("full_volt", bus.voltage_mV, 16'd4998);

        // Ramp 0..15 back-to-back: exactly one result
        pulse_reset();
        n_valid = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'(i), 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("ramp_one_valid", n_valid, 1);
        check_eq("ramp_avg", bus.avg_out, 12'd7);
        check_eq("ramp_volt", bus.voltage_mV, 16'd8);

        // Clear with a coincident strobe while running
        cycle(1'b1, 12'h123, 1'b1);
        check_eq("clr_filled", bus.filled, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("clr_no_valid", bus.avg_valid, 1'b0);
        check_eq("clr_hold_avg", bus.avg_out, 12'd7);
        check_eq("clr_hold_volt", bus.voltage_mV, 16'd8);
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'h400, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("refill_avg", bus.avg_out, 12'h400);
        check_eq("refill_volt", bus.voltage_mV, 16'd1250);

        // Reset mid-run, then verify the window must refill completely
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h3A5, 1'b0);
        pulse_reset();
        n_valid = 0;
        for (int i = 0; i < 15; i++) cycle(1'b1, 12'h0F0, 1'b0);
        check_eq("rst_refill_no_valid", n_valid, 0);
        cycle(1'b1, 12'h0F0, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        check_eq("rst_refill_valid", n_valid, 1);

        // Random traffic; clear is only issued after an idle cycle
        prev_strb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            strb = ($urandom_range(0, 3) != 0);
            clr  = !prev_strb && ($urandom_range(0, 63) == 0);
            cycle(strb, 12'($urandom_range(0, 4095)), clr);
            prev_strb = strb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
